// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy, thresholds and sticky errors.
// Optional first-word-fall-through read mode enabled by SYNC_FIFO_FWFT_EN.  Rev 1.0
`default_nettype none

module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rd,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              wa;
  logic              ra;

  // Accepts are qualified by the count registered at the start of the cycle.
  assign wa = wr && !full;
  assign ra = rd && !empty;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  always_ff @(posedge clock) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wa) wptr <= wptr + 1'b1;
      if (ra) rptr <= rptr + 1'b1;
      case ({wa, ra})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (!rst && wa) mem[wptr] <= din;
  end

  // A new error in the same cycle as clr_err takes priority over the clear.
  always_ff @(posedge clock) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && !wa)   overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (rd && !ra)   underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; zero while empty so reset reads back 0.
  assign dout       = empty ? '0 : mem[rptr];
  assign dout_valid = !empty;
`else
  always_ff @(posedge clock) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= ra;
      if (ra) dout <= mem[rptr];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (default parameters).
`default_nettype none

module tb_sync_fifo_param;

  logic       clock = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] din;
  logic       rd;
  logic       clr_err;
  logic [7:0] dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clock(clock), .rst(rst), .wr(wr), .din(din), .rd(rd), .clr_err(clr_err),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dv", 32'(dout_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; din = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_state();

`ifndef SYNC_FIFO_FWFT_EN
    // Fill 0x00..0x0F and watch the thresholds move.
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; din = 8'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_ae", 32'(almost_empty), (i + 1 <= 2) ? 1 : 0);
      chk("fill_af", 32'(almost_full), (i + 1 >= 14) ? 1 : 0);
      chk("fill_full", 32'(full), (i + 1 == 16) ? 1 : 0);
    end
    din = 8'hAA;
    tick();
    wr = 1'b0;
    chk("ovf_count", 32'(count), 16);
    chk("ovf_flag", 32'(overflow), 1);

    // First read cycle also writes while full: read wins, write dropped.
    for (int i = 0; i < 16; i++) begin
      rd = 1'b1; wr = (i == 0); din = 8'hBB;
      tick();
      chk("drain_dout", 32'(dout), 32'(i));
      chk("drain_dv", 32'(dout_valid), 1);
      chk("drain_count", 32'(count), 32'(15 - i));
    end
    wr = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    tick();
    rd = 1'b0;
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_dout", 32'(dout), 32'h0F);
    chk("udf_dv", 32'(dout_valid), 0);

    // Empty with rd&&wr: write accepted, read rejected.
    rd = 1'b1; wr = 1'b1; din = 8'h10;
    tick();
    chk("empty_rw_count", 32'(count), 1);
    chk("empty_rw_dv", 32'(dout_valid), 0);
    rd = 1'b0;
    for (int i = 1; i < 5; i++) begin
      din = 8'(8'h10 + i);
      tick();
    end
    wr = 1'b0;
    chk("five_count", 32'(count), 5);

    // Simultaneous read/write at count 5.
    for (int i = 0; i < 10; i++) begin
      rd = 1'b1; wr = 1'b1; din = 8'(8'h20 + i);
      tick();
      chk("rw_count", 32'(count), 5);
      chk("rw_dout", 32'(dout), (i < 5) ? 32'(8'h10 + i) : 32'(8'h20 + i - 5));
    end
    wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rw_tail", 32'(dout), 32'(8'h25 + i));
    end
    rd = 1'b0;
    chk("rw_empty", 32'(empty), 1);

    // Stream 40 words at occupancy 8 so both pointers wrap.
    wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 8'(8'h40 + i);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      rd = 1'b1; din = 8'(8'h48 + i);
      tick();
      chk("stream_dout", 32'(dout), 32'(8'h40 + i));
      chk("stream_count", 32'(count), 8);
    end
    wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stream_tail", 32'(dout), 32'(8'h60 + i));
    end
    rd = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);

    // New error coincident with clr_err: set wins.
    rd = 1'b1; clr_err = 1'b1;
    tick();
    rd = 1'b0; clr_err = 1'b0;
    chk("set_wins_udf", 32'(underflow), 1);

    // Reset at count 9 with traffic in the reset cycle.
    wr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      din = 8'(8'h80 + i);
      tick();
    end
    wr = 1'b0;
    chk("pre_rst_count", 32'(count), 9);
    rst = 1'b1; wr = 1'b1; rd = 1'b1; din = 8'hEE;
    tick();
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    chk_reset_state();
    wr = 1'b1; din = 8'h77;
    tick();
    wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("post_rst_dout", 32'(dout), 32'h77);
    chk("post_rst_dv", 32'(dout_valid), 1);
    chk("post_rst_empty", 32'(empty), 1);
`else
    // FWFT: written word appears on dout without a read.
    wr = 1'b1; din = 8'h5A;
    tick();
    wr = 1'b0;
    chk("fwft_dout", 32'(dout), 32'h5A);
    chk("fwft_dv", 32'(dout_valid), 1);
    chk("fwft_count", 32'(count), 1);
    tick();
    chk("fwft_hold", 32'(dout), 32'h5A);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("fwft_pop_empty", 32'(empty), 1);
    chk("fwft_pop_dv", 32'(dout_valid), 0);
    wr = 1'b1; din = 8'h11;
    tick();
    din = 8'h22;
    tick();
    wr = 1'b0;
    chk("fwft_head1", 32'(dout), 32'h11);
    rd = 1'b1;
    tick();
    chk("fwft_head2", 32'(dout), 32'h22);
    chk("fwft_count2", 32'(count), 1);
    tick();
    chk("fwft_empty2", 32'(empty), 1);
    tick();
    rd = 1'b0;
    chk("fwft_udf", 32'(underflow), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
